// File: rtl/apb3_pkg.sv
// apb3_pkg: shared types and decode constants for the APB3 master controller.
package apb3_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {TGT_S1, TGT_S2, TGT_NONE} tgt_t;
  localparam logic [1:0] REGION_S1 = 2'b00;
  localparam logic [1:0] REGION_S2 = 2'b01;
endpackage

// File: rtl/apb3_addr_decode.sv
// apb3_addr_decode: maps the address region bits to an APB slave target.
import apb3_pkg::*;
module apb3_addr_decode (
  input  logic [1:0] region,
  output tgt_t       tgt
);
  always_comb tgt = region == REGION_S1 ? TGT_S1 : region == REGION_S2 ? TGT_S2 : TGT_NONE;
endmodule

// File: rtl/apb3_master_ctrl.sv
// apb3_master_ctrl: sequences single local requests onto a two-slave APB3 bus
// with address decode, wait-state tolerance and timeout/decode-miss errors.
import apb3_pkg::*;
module apb3_master_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic              psel1,
  output logic              psel2,
  output logic              penable,
  input  logic              pready1,
  input  logic              pready2,
  input  logic [DATA_W-1:0] prdata1,
  input  logic [DATA_W-1:0] prdata2
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t            state;
  tgt_t              tgt, dec_tgt;
  logic [CW-1:0]     cnt;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  apb3_addr_decode u_dec (.region(req_addr[13:12]), .tgt(dec_tgt));
  assign req_ready = state == IDLE;
  // only the registered target's handshake is ever looked at
  always_comb begin
    sel_ready = tgt == TGT_S2 ? pready2 : pready1;
    sel_rdata = tgt == TGT_S2 ? prdata2 : prdata1;
  end
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      tgt       <= TGT_S1;
      cnt       <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      psel1     <= 1'b0;
      psel2     <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          paddr  <= req_addr;
          pwrite <= req_write;
          pwdata <= req_wdata;
          tgt    <= dec_tgt;
          cnt    <= '0;
          if (dec_tgt == TGT_NONE) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state <= SETUP;
            psel1 <= dec_tgt == TGT_S1;
            psel2 <= dec_tgt == TGT_S2;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          cnt <= cnt + CW'(1);
          // pready on the last allowed cycle still wins over the timeout
          if (sel_ready || cnt == CW'(TIMEOUT - 1)) begin
            state     <= RESP;
            psel1     <= 1'b0;
            psel2     <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= !sel_ready;
            rsp_rdata <= sel_ready && !pwrite ? sel_rdata : '0;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb3_master_ctrl.sv
// tb_apb3_master_ctrl: randomized and directed transfers checked against a
// transaction-level model of latency, error, data and bus-select behaviour.
module tb_apb3_master_ctrl;
  localparam int TO = 16;
  logic        pclk = 1'b0;
  logic        preset = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic        pwrite, psel1, psel2, penable;
  logic        pready1 = 1'b0, pready2 = 1'b0;
  logic [31:0] prdata1 = '0, prdata2 = '0;
  int          checks = 0, errors = 0;

  apb3_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel1(psel1), .psel2(psel2),
    .penable(penable), .pready1(pready1), .pready2(pready2),
    .prdata1(prdata1), .prdata2(prdata2)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!req_ready && g < 50) begin
      @(negedge pclk);
      g++;
    end
    if (!req_ready) check("ready_timeout", 0, 1);
  endtask

  // One transfer; the slave raises pready on ACCESS cycle number `waits` (0-based).
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input int waits, input logic [31:0] rd);
    int lat = 0, acc = 0, setups = 0, wrong = 0, unstable = 0;
    int exp_lat, exp_acc;
    logic got_err = 1'b0;
    logic [31:0] got_rd = '0;
    logic [1:0] region;
    bit miss, s2, ok, done = 0;
    region = addr[13:12];
    miss = region[1];
    s2 = region == 2'b01;
    ok = !miss && waits < TO;
    wait_ready();
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge pclk);
    #1 req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = $urandom;
    for (int c = 1; c <= TO + 30 && !done; c++) begin
      @(negedge pclk);
      pready1 = $urandom; pready2 = $urandom; prdata1 = $urandom; prdata2 = $urandom;
      if ((s2 ? psel2 : psel1) && penable) begin
        if (s2) begin
          pready2 = acc == waits;
          if (acc == waits) prdata2 = rd;
        end else begin
          pready1 = acc == waits;
          if (acc == waits) prdata1 = rd;
        end
        acc++;
      end
      if ((s2 ? psel1 : psel2) || (miss && (psel1 || psel2))) wrong++;
      if ((psel1 || psel2) && !penable) setups++;
      if ((psel1 || psel2) && (paddr !== addr || pwrite !== wr || pwdata !== wd)) unstable++;
      if (rsp_valid) begin
        lat = c; got_err = rsp_err; got_rd = rsp_rdata; done = 1;
      end
    end
    if (!done) check("rsp_never_seen", 0, 1);
    exp_lat = miss ? 1 : ok ? 3 + waits : 2 + TO;
    exp_acc = miss ? 0 : ok ? waits + 1 : TO;
    check("latency", lat, exp_lat);
    check("access_cycles", acc, exp_acc);
    check("setup_cycles", setups, miss ? 0 : 1);
    check("wrong_select", wrong, 0);
    check("bus_unstable", unstable, 0);
    check("rsp_err", got_err, !ok);
    check("rsp_rdata", got_rd, (ok && !wr) ? rd : 32'h0);
    @(negedge pclk);
    check("rsp_one_cycle", rsp_valid, 0);
    check("ready_after", req_ready, 1);
  endtask

  initial begin
    int t, last, g, seen;
    logic [31:0] a, d;
    #1 preset = 1'b1;
    #2;
    check("rst_paddr", paddr, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_psel1", psel1, 0);
    check("rst_psel2", psel2, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_req_ready", req_ready, 1);
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);

    xfer(1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 0, 32'h0);
    xfer(1'b0, 32'h0000_1004, 32'h0, 3, 32'h1234_5678);
    xfer(1'b0, 32'h0000_2000, 32'h0, 0, 32'h0);
    xfer(1'b1, 32'h0000_3ABC, 32'h5555_AAAA, 0, 32'h0);
    xfer(1'b0, 32'h0000_0010, 32'h0, TO, 32'hAAAA_0001);
    xfer(1'b0, 32'h0000_0010, 32'h0, TO - 1, 32'h5555_1234);
    xfer(1'b0, 32'h0000_1010, 32'h0, TO - 2, 32'h0BAD_F00D);

    // Reset during ACCESS: bus and response drop at once, transfer is lost.
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040; req_wdata = '0;
    pready1 = 1'b0; pready2 = 1'b0;
    @(posedge pclk);
    #1 req_valid = 1'b0;
    g = 0;
    while (!(psel1 && penable) && g < 10) begin
      @(negedge pclk);
      pready1 = 1'b0;
      g++;
    end
    check("reached_access", psel1 && penable, 1);
    @(negedge pclk);
    #2 preset = 1'b1;
    #1;
    check("arst_psel1", psel1, 0);
    check("arst_psel2", psel2, 0);
    check("arst_penable", penable, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_req_ready", req_ready, 1);
    @(negedge pclk);
    preset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (rsp_valid) seen++;
    end
    check("arst_no_rsp", seen, 0);
    xfer(1'b1, 32'h0000_1100, 32'hCAFE_0001, 1, 32'h0);

    // Back-to-back requests with req_valid held high and zero-wait slaves.
    pready1 = 1'b1; pready2 = 1'b1;
    t = 0; last = 0;
    req_valid = 1'b1; req_write = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = 0;
      while (!req_ready && g < 20) begin
        @(negedge pclk);
        t++; g++;
      end
      if (k > 0) check("b2b_gap", t - last, 4);
      last = t;
      a = ($urandom & 32'hFFFF_DFFC) | 32'h0000_0004;
      d = $urandom;
      req_addr = a; req_wdata = d;
      seen = 0;
      for (int j = 0; j < 3; j++) begin
        @(negedge pclk);
        t++;
        if (j < 2 && (paddr !== a || pwdata !== d || pwrite !== 1'b1)) seen++;
        if (j == 2) check("b2b_rsp", {rsp_valid, rsp_err}, 2'b10);
      end
      check("b2b_stable", seen, 0);
    end
    req_valid = 1'b0;
    @(negedge pclk);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] rg;
      int w;
      rg = $urandom_range(0, 9) < 8 ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      w = $urandom_range(0, 9) < 7 ? $urandom_range(0, 4) : $urandom_range(TO - 3, TO + 2);
      a = ($urandom & 32'hFFFF_CFFF) | {18'h0, rg, 12'h0};
      xfer(1'($urandom), a, $urandom, w, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb3_master_ctrl.md
# apb3_master_ctrl

APB3 master controller that sequences single read/write transfers from a local request port onto the APB bus shared by the two slaves (`slave_one`, `slave_two`). It performs address decode to `psel1`/`psel2`, runs the IDLE/SETUP/ACCESS protocol, tolerates slave wait states via `pready`, and returns one response per request. It also flags decode misses and slave timeouts as errors.

## Interface
Parameters:
- `ADDR_W`, 32, address width; at least 14.
- `DATA_W`, 32, data width; matches the slaves.
- `TIMEOUT`, 16, maximum ACCESS cycles without `pready` before abort; at least 1.

Ports:
- `pclk` in 1: clock. One clock; all logic on the rising edge.
- `preset` in 1: reset, asynchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: transfer address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out DATA_W: read data; 0 for writes and errors.
- `rsp_err` out 1: decode miss or timeout; qualified by `rsp_valid`.
- `paddr` out ADDR_W: APB address.
- `pwrite` out 1: APB direction.
- `pwdata` out DATA_W: APB write data.
- `psel1` out 1: select for slave one.
- `psel2` out 1: select for slave two.
- `penable` out 1: APB enable.
- `pready1` in 1: ready from slave one.
- `pready2` in 1: ready from slave two.
- `prdata1` in DATA_W: read data from slave one.
- `prdata2` in DATA_W: read data from slave two.

## Operation
- Decode on `req_addr[13:12]`: 2'b00 selects slave one; 2'b01 selects slave two; 2'b10 and 2'b11 are a decode miss.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, register addr, write, wdata and the decoded target.
  - Valid target: go to SETUP.
  - Decode miss: go to RESP with error set; no select is asserted.
- SETUP: the target `psel` is 1 and `penable` is 0. Always go to ACCESS next cycle.
- ACCESS: the target `psel` is 1 and `penable` is 1.
  - The wait counter increments each ACCESS cycle.
  - If the selected `pready` is 1: capture the selected `prdata` on reads, then go to RESP with no error.
  - Otherwise, if the counter equals TIMEOUT-1: go to RESP with error set.
  - Otherwise: stay in ACCESS.
- RESP:
  - `rsp_valid`=1 for exactly one cycle; `psel*` and `penable` are 0.
  - `rsp_rdata` is the captured data, or 0 on a write or error.
  - Return to IDLE.
- `pready` and `prdata` from the unselected slave are ignored at all times.
- `paddr`, `pwrite` and `pwdata` are registered at accept and held stable through SETUP and ACCESS. They keep their value afterwards until the next accept.
- The wait counter clears on entry to SETUP. Its width is `$clog2(TIMEOUT+1)`.
- There is no response backpressure: the consumer must sample `rsp_valid` every cycle.

## Timing
- Reset values: state IDLE, `req_ready`=1 (decoded from IDLE), counter 0. All other outputs are 0: `paddr`, `pwrite`, `pwdata`, `psel1`, `psel2`, `penable`, `rsp_valid`, `rsp_rdata`, `rsp_err`.
- `req_ready` is decoded from state, and `req_valid` is sampled only in IDLE.
- Zero-wait transfer, with accept at edge T:
  - SETUP in cycle T+1.
  - ACCESS with `pready` in cycle T+2.
  - `rsp_valid` in cycle T+3.
  - `req_ready` again in cycle T+4.
  - Minimum period per transfer is 4 cycles.
- Each wait state adds one cycle.
- Timeout: after exactly TIMEOUT ACCESS cycles without `pready`, RESP follows with `rsp_err`=1.
- Decode miss: accept at T, `rsp_valid` with `rsp_err`=1 in cycle T+1, IDLE at T+2.
- `pready` arriving in the same ACCESS cycle as the timeout limit counts as success.
- Reset asserted mid-transfer:
  - `psel*`, `penable` and `rsp_valid` drop immediately.
  - No response is issued; the transfer is lost.
  - The controller resumes in IDLE.

## Structure
- Package `apb3_pkg`:
  - state enum (IDLE, SETUP, ACCESS, RESP);
  - region constants (REGION_S1=2'b00, REGION_S2=2'b01);
  - target enum (TGT_S1, TGT_S2, TGT_NONE).
- Sub-module `apb3_addr_decode`: combinational, `req_addr[13:12]` to target enum. It is reused by future slaves.
- Top level: FSM, wait counter, and the address/data/response registers.

## Test plan
- Write 0xDEADBEEF to 0x0000_0000, `pready1` tied 1 -> SETUP then ACCESS on `psel1`, then `rsp_valid`=1 with `rsp_err`=0 and `rsp_rdata`=0, 3 cycles after accept.
- Read 0x0000_1004 with `pready2` low for 3 ACCESS cycles, then high with `prdata2`=0x12345678 -> 3 wait states, `rsp_rdata`=0x12345678, `psel1` never asserted.
- Read 0x0000_2000 -> no `psel` asserted, `rsp_valid` and `rsp_err`=1 one cycle after accept, `rsp_rdata`=0.
- With TIMEOUT=16, slave one `pready1` held 0 -> exactly 16 ACCESS cycles, then `rsp_err`=1 and `psel1`/`penable` drop. Repeat with `pready1` rising on the 16th ACCESS cycle -> success, no error.
- Assert `preset` during ACCESS -> `psel*`, `penable` and `rsp_valid` go to 0 asynchronously and no response appears. A subsequent write completes normally.
- Back-to-back `req_valid` held high -> accepts are spaced 4 cycles apart, and `paddr`/`pwdata` stay stable through every SETUP and ACCESS.
